// File: rtl/bcharger_timed.sv
// Single-cell charge-phase controller with debounce, phase timeouts and fault latch.
// Optional thermal pause feature is enabled by defining BCHG_TEMP_EN.
module bcharger_timed #(
   parameter int DEB_N    = 4,
   parameter int TRKL_TMO = 1024,
   parameter int CHG_TMO  = 65536
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       en,
   input  logic       vtrkl,
   input  logic       vterm,
   input  logic       iterm,
   input  logic       vrchrg,
   input  logic       fault_clr,
`ifdef BCHG_TEMP_EN
   input  logic       temp_ok,
   output logic       paused,
`endif
   output logic       trkl,
   output logic       fast,
   output logic       vconst,
   output logic       done,
   output logic       fault,
   output logic [1:0] fault_code
);

   localparam int DW = $clog2(DEB_N + 1);
   localparam int TW = (TRKL_TMO > 0) ? $clog2(TRKL_TMO + 1) : 1;
   localparam int CW = (CHG_TMO > 0) ? $clog2(CHG_TMO + 1) : 1;

   localparam logic [DW-1:0] DEB_LAST  = DW'(DEB_N - 1);
   localparam logic [DW-1:0] DEB_ONE   = DW'(1);
   localparam logic [TW-1:0] TRKL_LAST = TW'(TRKL_TMO - 1);
   localparam logic [TW-1:0] TRKL_MAX  = TW'(TRKL_TMO);
   localparam logic [TW-1:0] TRKL_ONE  = TW'(1);
   localparam logic [CW-1:0] CHG_LAST  = CW'(CHG_TMO - 1);
   localparam logic [CW-1:0] CHG_MAX   = CW'(CHG_TMO);
   localparam logic [CW-1:0] CHG_ONE   = CW'(1);
   localparam logic          TRKL_ON   = (TRKL_TMO > 0);
   localparam logic          CHG_ON    = (CHG_TMO > 0);

   typedef enum logic [2:0] {
      S_OFF    = 3'd0,
      S_TRKL   = 3'd1,
      S_FAST   = 3'd2,
      S_VCONST = 3'd3,
      S_DONE   = 3'd4,
      S_FAULT  = 3'd5
   } state_t;

   state_t          state;
   state_t          nxt;
   logic [1:0]      code_nxt;
   logic [DW-1:0]   deb_cnt;
   logic [TW-1:0]   trkl_tmr;
   logic [CW-1:0]   chg_tmr;
   logic            cond;
   logic            active;
   logic            temp_good;
   logic            hold;
   logic            deb_hit;
   logic            trkl_to;
   logic            chg_to;

`ifdef BCHG_TEMP_EN
   assign temp_good = temp_ok;
`else
   assign temp_good = 1'b1;
`endif

   // Exit condition, pause qualification, debounce and timeout decode
   always_comb begin
      cond = 1'b0;
      case (state)
         S_TRKL:   cond = vtrkl;
         S_FAST:   cond = vterm;
         S_VCONST: cond = iterm;
         S_DONE:   cond = vrchrg;
         default:  cond = 1'b0;
      endcase
      active  = (state == S_TRKL) || (state == S_FAST) ||
                (state == S_VCONST);
      hold    = active && en && !temp_good;
      deb_hit = cond && (deb_cnt == DEB_LAST) && !hold;
      trkl_to = TRKL_ON && (state == S_TRKL) &&
                (trkl_tmr == TRKL_LAST) && !hold;
      chg_to  = CHG_ON && ((state == S_FAST) || (state == S_VCONST)) &&
                (chg_tmr == CHG_LAST) && !hold;
   end

   // Next-state selection: fault latch, enable override, pause, phase flow
   always_comb begin
      nxt      = state;
      code_nxt = fault_code;
      if (state == S_FAULT) begin
         if (fault_clr) begin
            nxt      = S_OFF;
            code_nxt = 2'b00;
         end
      end else if (!en) begin
         nxt = S_OFF;
      end else if (!hold) begin
         case (state)
            S_OFF: nxt = S_TRKL;
            S_TRKL: begin
               if (deb_hit) begin
                  nxt = S_FAST;
               end else if (trkl_to) begin
                  nxt      = S_FAULT;
                  code_nxt = 2'b01;
               end
            end
            S_FAST: begin
               if (deb_hit) begin
                  nxt = S_VCONST;
               end else if (chg_to) begin
                  nxt      = S_FAULT;
                  code_nxt = 2'b10;
               end
            end
            S_VCONST: begin
               if (deb_hit) begin
                  nxt = S_DONE;
               end else if (chg_to) begin
                  nxt      = S_FAULT;
                  code_nxt = 2'b10;
               end
            end
            S_DONE: begin
               if (deb_hit) nxt = S_TRKL;
            end
            default: nxt = S_OFF;
         endcase
      end
   end

   // State, counters and registered one-hot mode outputs
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= S_OFF;
         deb_cnt    <= '0;
         trkl_tmr   <= '0;
         chg_tmr    <= '0;
         trkl       <= 1'b0;
         fast       <= 1'b0;
         vconst     <= 1'b0;
         done       <= 1'b0;
         fault      <= 1'b0;
         fault_code <= 2'b00;
`ifdef BCHG_TEMP_EN
         paused     <= 1'b0;
`endif
      end else begin
         state      <= nxt;
         fault_code <= code_nxt;

         if ((nxt != state) || !cond || hold)
            deb_cnt <= '0;
         else
            deb_cnt <= deb_cnt + DEB_ONE;

         if ((nxt == S_OFF) || ((nxt == S_TRKL) && (state != S_TRKL)))
            trkl_tmr <= '0;
         else if ((state == S_TRKL) && !hold && (trkl_tmr != TRKL_MAX))
            trkl_tmr <= trkl_tmr + TRKL_ONE;

         if ((nxt == S_OFF) || ((nxt == S_FAST) && (state != S_FAST)))
            chg_tmr <= '0;
         else if (((state == S_FAST) || (state == S_VCONST)) && !hold &&
                  (chg_tmr != CHG_MAX))
            chg_tmr <= chg_tmr + CHG_ONE;

         trkl   <= (nxt == S_TRKL)   && !hold;
         fast   <= (nxt == S_FAST)   && !hold;
         vconst <= (nxt == S_VCONST) && !hold;
         done   <= (nxt == S_DONE);
         fault  <= (nxt == S_FAULT);
`ifdef BCHG_TEMP_EN
         paused <= hold;
`endif
      end
   end

endmodule

// File: tb/tb_bcharger_timed.sv
// Scoreboard bench for bcharger_timed: a DEB_N=4 and a DEB_N=1 instance
// share stimulus; expected outputs are queued per edge and checked after it.
module tb_bcharger_timed;

   logic clk = 1'b0;
   logic reset, en, vtrkl, vterm, iterm, vrchrg, fault_clr, temp_ok;

   logic t4, f4, v4, d4, x4, p4;
   logic t1, f1, v1, d1, x1, p1;
   logic [1:0] c4, c1;

   logic       sel;
   logic [7:0] obs;

   int n_chk = 0;
   int n_err = 0;

   logic [7:0] exp_q[$];
   string      tag_q[$];

   localparam logic [7:0] O_OFF  = 8'b0_00000_00;
   localparam logic [7:0] O_TRKL = 8'b0_10000_00;
   localparam logic [7:0] O_FAST = 8'b0_01000_00;
   localparam logic [7:0] O_VC   = 8'b0_00100_00;
   localparam logic [7:0] O_DONE = 8'b0_00010_00;
   localparam logic [7:0] O_F1   = 8'b0_00001_01;
   localparam logic [7:0] O_F2   = 8'b0_00001_10;
   localparam logic [7:0] O_PF   = 8'b1_00000_00;

   always #5 clk = ~clk;

   bcharger_timed #(.DEB_N(4), .TRKL_TMO(16), .CHG_TMO(32)) u4 (
      .clk(clk), .reset(reset), .en(en), .vtrkl(vtrkl), .vterm(vterm),
      .iterm(iterm), .vrchrg(vrchrg), .fault_clr(fault_clr),
`ifdef BCHG_TEMP_EN
      .temp_ok(temp_ok), .paused(p4),
`endif
      .trkl(t4), .fast(f4), .vconst(v4), .done(d4), .fault(x4),
      .fault_code(c4)
   );

   bcharger_timed #(.DEB_N(1), .TRKL_TMO(16), .CHG_TMO(32)) u1 (
      .clk(clk), .reset(reset), .en(en), .vtrkl(vtrkl), .vterm(vterm),
      .iterm(iterm), .vrchrg(vrchrg), .fault_clr(fault_clr),
`ifdef BCHG_TEMP_EN
      .temp_ok(temp_ok), .paused(p1),
`endif
      .trkl(t1), .fast(f1), .vconst(v1), .done(d1), .fault(x1),
      .fault_code(c1)
   );

`ifndef BCHG_TEMP_EN
   assign p4 = 1'b0;
   assign p1 = 1'b0;
`endif

   always_comb begin
      obs = 8'h00;
      if (sel) obs = {p1, t1, f1, v1, d1, x1, c1};
      else     obs = {p4, t4, f4, v4, d4, x4, c4};
   end

   task automatic check(input string tag, input logic [7:0] got,
                        input logic [7:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%b exp=%b", tag, got, exp);
      end
   endtask

   task automatic step(input logic [7:0] e, input string tag);
      logic [7:0] ev;
      string      tv;
      exp_q.push_back(e);
      tag_q.push_back(tag);
      @(posedge clk);
      #1;
      ev = exp_q.pop_front();
      tv = tag_q.pop_front();
      check(tv, obs, ev);
   endtask

   task automatic steps(input int n, input logic [7:0] e, input string tag);
      for (int i = 0; i < n; i++) step(e, $sformatf("%s%0d", tag, i));
   endtask

   task automatic do_reset;
      reset = 1'b1; en = 1'b0; vtrkl = 1'b0; vterm = 1'b0; iterm = 1'b0;
      vrchrg = 1'b0; fault_clr = 1'b0; temp_ok = 1'b1;
      #1;
      check("rst", obs, O_OFF);
      @(posedge clk);
      @(negedge clk);
      reset = 1'b0;
   endtask

   initial begin
      sel = 1'b0;
      do_reset();

      // debounce, DEB_N=4: 3 high, 1 low, 4 high
      en = 1'b1;
      step(O_TRKL, "a_entry");
      vtrkl = 1'b1;
      steps(3, O_TRKL, "a_burst");
      vtrkl = 1'b0;
      step(O_TRKL, "a_gap");
      vtrkl = 1'b1;
      steps(3, O_TRKL, "a_hold");
      step(O_FAST, "a_fast");
      vtrkl = 1'b0;

      // full cycle, DEB_N=1
      sel = 1'b1;
      do_reset();
      en = 1'b1;
      step(O_TRKL, "b_trkl");
      vtrkl = 1'b1; step(O_FAST, "b_fast"); vtrkl = 1'b0;
      vterm = 1'b1; step(O_VC, "b_vc"); vterm = 1'b0;
      iterm = 1'b1; step(O_DONE, "b_done"); iterm = 1'b0;
      step(O_DONE, "b_idle");
      vrchrg = 1'b1; step(O_TRKL, "b_rchg"); vrchrg = 1'b0;
      fault_clr = 1'b1; step(O_TRKL, "b_clr_noop"); fault_clr = 1'b0;

      // trickle timeout at the 16th edge in TRKL
      do_reset();
      en = 1'b1;
      step(O_TRKL, "c_entry");
      steps(15, O_TRKL, "c_t");
      step(O_F1, "c_tmo");
      en = 1'b0; step(O_F1, "c_en_lo");
      en = 1'b1; step(O_F1, "c_latched");
      fault_clr = 1'b1; step(O_OFF, "c_clr");
      fault_clr = 1'b0; step(O_TRKL, "c_retry");

      // charge timeout: 20 edges in FAST, then VCONST until edge 32
      do_reset();
      en = 1'b1;
      step(O_TRKL, "d_entry");
      vtrkl = 1'b1; step(O_FAST, "d_fast"); vtrkl = 1'b0;
      steps(19, O_FAST, "d_f");
      vterm = 1'b1; step(O_VC, "d_vc20"); vterm = 1'b0;
      steps(11, O_VC, "d_v");
      step(O_F2, "d_tmo32");
      fault_clr = 1'b1; step(O_OFF, "d_clr"); fault_clr = 1'b0;

      // same run, iterm qualifies on edge 32: transition beats timeout
      do_reset();
      en = 1'b1;
      step(O_TRKL, "e_entry");
      vtrkl = 1'b1; step(O_FAST, "e_fast"); vtrkl = 1'b0;
      steps(19, O_FAST, "e_f");
      vterm = 1'b1; step(O_VC, "e_vc20"); vterm = 1'b0;
      steps(11, O_VC, "e_v");
      iterm = 1'b1; step(O_DONE, "e_done32"); iterm = 1'b0;
      step(O_DONE, "e_nofault");

      // en low in VCONST, then async reset mid-cycle
      do_reset();
      en = 1'b1;
      step(O_TRKL, "g_entry");
      vtrkl = 1'b1; step(O_FAST, "g_fast"); vtrkl = 1'b0;
      vterm = 1'b1; step(O_VC, "g_vc"); vterm = 1'b0;
      en = 1'b0; step(O_OFF, "g_en_off");
      en = 1'b1; step(O_TRKL, "g_reentry");
      vtrkl = 1'b1; step(O_FAST, "g_fast2"); vtrkl = 1'b0;
      vterm = 1'b1; step(O_VC, "g_vc2"); vterm = 1'b0;
      #2;
      reset = 1'b1;
      #1;
      check("g_async", obs, O_OFF);

`ifdef BCHG_TEMP_EN
      // thermal pause of 10 edges delays the charge timeout by 10
      do_reset();
      en = 1'b1;
      step(O_TRKL, "h_entry");
      vtrkl = 1'b1; step(O_FAST, "h_fast"); vtrkl = 1'b0;
      steps(5, O_FAST, "h_f");
      temp_ok = 1'b0;
      steps(10, O_PF, "h_pause");
      temp_ok = 1'b1;
      steps(26, O_FAST, "h_r");
      step(O_F2, "h_tmo42");
`endif

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/bcharger_timed.md
Name: bcharger_timed

Overview:
- Parametrised successor of the single-cell charge-phase controller.
- Sequences trickle -> fast (constant current) -> constant voltage -> done -> recharge, as before.
- Adds per-transition comparator debounce, per-phase safety timeouts with a latched FAULT state, and a charge-enable input.
- Sits between the analog comparator outputs (vtrkl, vterm, iterm, vrchrg) and the charger power-stage mode controls.

Parameters:
- DEB_N, 4, consecutive sampled-high clk edges a comparator must hold before its transition is taken; legal range 1..255; 1 gives the original immediate behaviour.
- TRKL_TMO, 1024, maximum cycles in TRKL before a trickle-timeout fault; 0 disables.
- CHG_TMO, 65536, maximum cycles in FAST and VCONST combined before a charge-timeout fault; 0 disables.

Ports:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous, active-high reset
- en  input  1  charge enable; low forces OFF
- vtrkl  input  1  battery above trickle threshold
- vterm  input  1  battery at termination voltage
- iterm  input  1  charge current below termination current
- vrchrg  input  1  battery below recharge threshold
- fault_clr  input  1  clears a latched fault
- trkl  output  1  trickle mode active
- fast  output  1  fast (CC) mode active
- vconst  output  1  constant-voltage mode active
- done  output  1  charge complete
- fault  output  1  fault latched
- fault_code  output  2  00 none, 01 trickle timeout, 10 charge timeout

Behaviour:
- States: OFF, TRKL, FAST, VCONST, DONE, FAULT (3-bit encoding).
- Outputs are registered and one-hot with the state: trkl/fast/vconst/done/fault each high only in its own state; OFF drives all five low. Each output updates on the same edge the state changes (driven from next-state).
- Reset: state=OFF, all outputs 0, fault_code=00, timers and debounce counter 0.
- Debounce:
  - One counter deb_cnt, width $clog2(DEB_N+1).
  - Increments on each edge where the current state's exit condition is high; clears on any edge where it is low, and on every state change.
  - The transition is taken on the DEB_N-th consecutive high edge.
- Transitions (en high):
  - OFF -> TRKL unconditionally on the next edge.
  - TRKL -> FAST on debounced vtrkl.
  - FAST -> VCONST on debounced vterm.
  - VCONST -> DONE on debounced iterm.
  - DONE -> TRKL on debounced vrchrg.
  - FAULT -> OFF only on an edge with fault_clr=1; fault and fault_code clear on that edge.
- Timers:
  - trkl_tmr counts edges spent in TRKL and clears on TRKL entry.
  - chg_tmr counts edges spent in FAST and VCONST, clears on FAST entry, and is NOT cleared on FAST->VCONST.
  - Widths are $clog2(TMO+1); counters saturate and never wrap.
  - Timeout fires on the edge where the timer equals TMO-1 → FAULT, with fault_code 01 (from TRKL) or 10 (from FAST/VCONST).
- Simultaneous events:
  - A debounced transition and a timeout on the same edge: the transition wins, no fault.
  - en low overrides everything except FAULT: any other state goes to OFF next edge, clearing counters.
  - In FAULT, en is ignored; the fault stays latched until fault_clr.
  - fault_clr outside FAULT has no effect.
- Reset mid-operation: asynchronous return to the reset values above, from any state including FAULT.

Optional Feature:
- Macro BCHG_TEMP_EN.
- Defined:
  - Adds input temp_ok (1 bit) and output paused (1 bit, reset 0).
  - While temp_ok=0 in TRKL, FAST or VCONST: state is held; trkl/fast/vconst are forced 0; paused=1; the active timer freezes (keeps its value); deb_cnt clears.
  - When temp_ok returns to 1, the mode output reasserts on the next edge and counting resumes.
  - paused=0 in all other states; DONE, OFF and FAULT are unaffected by temp_ok.
- Undefined: temp_ok and paused do not exist; behaviour is identical to temp_ok tied high.

Test Plan:
- DEB_N=4: reset, en=1, vtrkl high for 3 edges then low for 1, then high for 4 edges -> trkl stays 1 through the first burst; fast=1 after the 4th consecutive edge.
- Full cycle, DEB_N=1: vtrkl, vterm, iterm each pulsed one cycle, then vrchrg -> trkl, fast, vconst, done, trkl follow one edge after each pulse; outputs always one-hot.
- TRKL_TMO=16, vtrkl held low -> fault=1 and fault_code=01 on the 16th edge in TRKL; en toggled low has no effect; fault_clr=1 -> OFF, then TRKL next edge, fault_code=00.
- CHG_TMO=32: 20 edges in FAST, vterm → VCONST, iterm low -> fault_code=10 at combined edge 32; a run with iterm qualifying exactly on edge 32 -> DONE, no fault.
- Mid-charge in VCONST: en=0 -> all outputs 0 next edge; async reset asserted between clock edges -> outputs 0 immediately.
- With BCHG_TEMP_EN: temp_ok=0 for 10 cycles in FAST with CHG_TMO=32 -> fast=0 and paused=1 during the 10 cycles; timeout arrives 10 cycles later than the non-paused run.
